// File: rtl/axis_egress_arbiter_if.sv
// Handshake bundle for the egress arbiter: NUM_PORTS packed ingress streams
// plus the single registered egress stream.
interface axis_egress_arbiter_if #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 1
);
  localparam int unsigned ID_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata;
  logic [NUM_PORTS-1:0]            s_tvalid;
  logic [NUM_PORTS-1:0]            s_tready;
  logic [NUM_PORTS-1:0]            s_tlast;
  logic [NUM_PORTS*USER_WIDTH-1:0] s_tuser;

  logic [DATA_WIDTH-1:0]           m_tdata;
  logic                            m_tvalid;
  logic                            m_tready;
  logic                            m_tlast;
  logic [USER_WIDTH-1:0]           m_tuser;
  logic [ID_WIDTH-1:0]             m_tid;

  // Arbiter view: sinks the ingress streams, sources the egress stream.
  modport master (
    input  s_tdata, s_tvalid, s_tlast, s_tuser, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, m_tuser, m_tid
  );

  // Environment view: sources the ingress streams, sinks the egress stream.
  modport slave (
    output s_tdata, s_tvalid, s_tlast, s_tuser, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, m_tuser, m_tid
  );
endinterface

// File: rtl/axis_egress_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXI streams onto one
// registered egress stream; the grant is held from first beat to tlast.
module axis_egress_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  axis_egress_arbiter_if.master bus
);
  localparam int unsigned ID_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state;
  logic [ID_WIDTH-1:0]   grant;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   pick;
  logic [ID_WIDTH-1:0]   rr_next;
  logic                  any_req;
  logic                  out_free;
  logic                  load;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [USER_WIDTH-1:0] sel_user;

  // Output register can take a new beat when empty or draining this cycle.
  assign out_free = !bus.m_tvalid || bus.m_tready;
  assign load     = (state == BUSY) && sel_valid && out_free;
  assign rr_next  = (grant == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : grant + ID_WIDTH'(1);

  // Round-robin search: first requester at rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  always_comb begin
    any_req = 1'b0;
    pick    = rr_ptr;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (!any_req && bus.s_tvalid[ID_WIDTH'((32'(rr_ptr) + k) % NUM_PORTS)]) begin
        any_req = 1'b1;
        pick    = ID_WIDTH'((32'(rr_ptr) + k) % NUM_PORTS);
      end
    end
  end

  // Select the granted port's beat and route ready back only to that port.
  always_comb begin
    sel_valid    = 1'b0;
    sel_last     = 1'b0;
    sel_data     = '0;
    sel_user     = '0;
    bus.s_tready = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant == ID_WIDTH'(i)) begin
        sel_valid          = bus.s_tvalid[i];
        sel_last           = bus.s_tlast[i];
        sel_data           = bus.s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_user           = bus.s_tuser[i*USER_WIDTH +: USER_WIDTH];
        bus.s_tready[i]    = (state == BUSY) && out_free;
      end
    end
  end

  // Arbitration FSM: latch a grant in IDLE, release it on the accepted tlast beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= pick;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (load && sel_last) begin
            state  <= IDLE;
            rr_ptr <= rr_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Egress register: load on accepted beat, hold while stalled, empty when drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m_tvalid <= 1'b0;
      bus.m_tdata  <= '0;
      bus.m_tuser  <= '0;
      bus.m_tlast  <= 1'b0;
      bus.m_tid    <= '0;
    end else if (load) begin
      bus.m_tvalid <= 1'b1;
      bus.m_tdata  <= sel_data;
      bus.m_tuser  <= sel_user;
      bus.m_tlast  <= sel_last;
      bus.m_tid    <= grant;
    end else if (bus.m_tvalid && bus.m_tready) begin
      bus.m_tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axis_egress_arbiter.sv
// Scoreboard bench for axis_egress_arbiter: per-test expected beats are queued
// in hand-computed grant order; a monitor pops and compares each egress beat.
module tb_axis_egress_arbiter;
  localparam int unsigned NP = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned UW = 1;
  localparam int unsigned IW = 2;
  localparam int unsigned EW = IW + 1 + UW + DW;

  logic clk;
  logic rst;

  axis_egress_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .USER_WIDTH(UW)) bus ();

  axis_egress_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] drv_data  [NP];
  logic [UW-1:0] drv_user  [NP];
  logic          drv_valid [NP];
  logic          drv_last  [NP];

  logic [EW-1:0] expq [$];
  int vectors;
  int miscompares;
  logic bp_on;
  logic p0_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack per-port driver state onto the ingress bus.
  always_comb begin
    bus.s_tdata  = '0;
    bus.s_tuser  = '0;
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    for (int i = 0; i < NP; i++) begin
      bus.s_tdata[i*DW +: DW] = drv_data[i];
      bus.s_tuser[i*UW +: UW] = drv_user[i];
      bus.s_tvalid[i]         = drv_valid[i];
      bus.s_tlast[i]          = drv_last[i];
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int p, input int pkt, input int b);
    return (DW'(p) << 32) | (DW'(pkt) << 8) | DW'(b);
  endfunction

  function automatic void push_pkt(input int p, input int pkt, input int n);
    for (int b = 0; b < n; b++)
      expq.push_back({IW'(p), (b == n - 1), UW'(b & 1), beat_data(p, pkt, b)});
  endfunction

  // Source one packet on port p; optional start delay and a valid gap after beat gap_after.
  task automatic drive_pkt(input int p, input int pkt, input int n, input int delay,
                           input int gap_after, input int gap_len);
    int t;
    if (delay > 0) begin
      repeat (delay) @(posedge clk);
      #1;
    end
    for (int b = 0; b < n; b++) begin
      drv_data[p]  = beat_data(p, pkt, b);
      drv_user[p]  = UW'(b & 1);
      drv_last[p]  = (b == n - 1);
      drv_valid[p] = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!bus.s_tready[IW'(p)] && t < 300);
      if (!bus.s_tready[IW'(p)]) begin
        chk("src_timeout", 128'(p), 128'(NP));
        drv_valid[p] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (b == gap_after) begin
        drv_valid[p] = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
    end
    drv_valid[p] = 1'b0;
    drv_last[p]  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 600) begin
      @(posedge clk);
      n++;
    end
    if (expq.size() != 0) begin
      chk("drain_timeout", 128'(expq.size()), 128'(0));
      expq.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [0:5]  single_pat;
  logic [0:16] rr_pat;

  initial begin
    vectors     = 0;
    miscompares = 0;
    bp_on       = 1'b0;
    p0_done     = 1'b0;
    single_pat  = 6'b001110;
    rr_pat      = 17'b00110110110110110;
    for (int i = 0; i < NP; i++) begin
      drv_data[i]  = '0;
      drv_user[i]  = '0;
      drv_valid[i] = 1'b0;
      drv_last[i]  = 1'b0;
    end
    bus.m_tready = 1'b1;
    rst = 1'b1;

    // Monitor: scoreboard pop on every egress handshake, stability and backpressure checks.
    fork
      begin : monitor
        logic [EW-1:0] held;
        logic          held_ok;
        logic [EW-1:0] cur;
        logic [EW-1:0] e;
        held_ok = 1'b0;
        held    = '0;
        forever begin
          @(negedge clk);
          cur = {bus.m_tid, bus.m_tlast, bus.m_tuser, bus.m_tdata};
          if (!rst && bus.m_tvalid && bus.m_tready) begin
            if (expq.size() == 0) begin
              chk("unexpected_beat", 128'(cur), 128'(0));
            end else begin
              e = expq.pop_front();
              chk("egress_beat", 128'(cur), 128'(e));
            end
          end
          if (!rst && bus.m_tvalid && !bus.m_tready) begin
            chk("stall_sready", 128'(bus.s_tready), 128'(0));
            if (held_ok) chk("stall_stable", 128'(cur), 128'(held));
            held    = cur;
            held_ok = 1'b1;
          end else begin
            held_ok = 1'b0;
          end
        end
      end
      begin : ready_gen
        forever begin
          @(posedge clk);
          #1;
          if (bp_on) bus.m_tready = 1'($urandom_range(0, 1));
        end
      end
    join_none

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_m_tvalid", 128'(bus.m_tvalid), 128'(0));
    chk("rst_m_tdata",  128'(bus.m_tdata),  128'(0));
    chk("rst_m_tlast",  128'(bus.m_tlast),  128'(0));
    chk("rst_m_tuser",  128'(bus.m_tuser),  128'(0));
    chk("rst_m_tid",    128'(bus.m_tid),    128'(0));
    chk("rst_s_tready", 128'(bus.s_tready), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single port 2, 3 beats: m_tvalid in cycles 2..4.
    push_pkt(2, 1, 3);
    fork
      drive_pkt(2, 1, 3, 0, -1, 0);
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        chk("single_m_tvalid", 128'(bus.m_tvalid), 128'(single_pat[c]));
      end
    join
    wait_drain();

    // Wrap-around: rr_ptr=3, ports 1 and 3 -> 3 first, then 1.
    push_pkt(3, 2, 2);
    push_pkt(1, 2, 2);
    fork
      drive_pkt(1, 2, 2, 0, -1, 0);
      drive_pkt(3, 2, 2, 0, -1, 0);
    join
    wait_drain();

    // Asynchronous reset mid-cycle with a stalled beat in the output register.
    bus.m_tready = 1'b0;
    drv_data[1]  = 64'hDEAD_BEEF_0000_0001;
    drv_user[1]  = 1'b1;
    drv_last[1]  = 1'b0;
    drv_valid[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_m_tvalid", 128'(bus.m_tvalid), 128'(1));
    chk("pre_rst_m_tid",    128'(bus.m_tid),    128'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("async_m_tvalid", 128'(bus.m_tvalid), 128'(0));
    chk("async_m_tdata",  128'(bus.m_tdata),  128'(0));
    chk("async_m_tuser",  128'(bus.m_tuser),  128'(0));
    chk("async_m_tid",    128'(bus.m_tid),    128'(0));
    chk("async_s_tready", 128'(bus.s_tready), 128'(0));
    drv_valid[1] = 1'b0;
    bus.m_tready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Round-robin from port 0 after reset: order 0,1,2,3,0 with one IDLE gap per packet.
    push_pkt(0, 3, 2);
    push_pkt(1, 3, 2);
    push_pkt(2, 3, 2);
    push_pkt(3, 3, 2);
    push_pkt(0, 4, 2);
    fork
      begin
        drive_pkt(0, 3, 2, 0, -1, 0);
        drive_pkt(0, 4, 2, 0, -1, 0);
      end
      drive_pkt(1, 3, 2, 0, -1, 0);
      drive_pkt(2, 3, 2, 0, -1, 0);
      drive_pkt(3, 3, 2, 0, -1, 0);
      for (int c = 0; c < 17; c++) begin
        @(negedge clk);
        chk("rr_m_tvalid", 128'(bus.m_tvalid), 128'(rr_pat[c]));
      end
    join
    wait_drain();

    // Backpressure: 16-beat packet from port 0 under random m_tready.
    push_pkt(0, 5, 16);
    bp_on = 1'b1;
    drive_pkt(0, 5, 16, 0, -1, 0);
    wait_drain();
    bp_on = 1'b0;
    bus.m_tready = 1'b1;
    @(posedge clk);
    #1;

    // Valid gap: port 0 holds grant through a 3-cycle gap while port 1 waits.
    push_pkt(0, 6, 4);
    push_pkt(1, 6, 2);
    p0_done = 1'b0;
    fork
      begin
        drive_pkt(0, 6, 4, 0, 1, 3);
        p0_done = 1'b1;
      end
      drive_pkt(1, 6, 2, 2, -1, 0);
      while (!p0_done) begin
        @(negedge clk);
        if (!p0_done) chk("gap_p1_sready", 128'(bus.s_tready[1]), 128'(0));
      end
    join
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axis_egress_arbiter.md
# axis_egress_arbiter

Packet-granular round-robin arbiter that merges NUM_PORTS internal AXI streams onto the single egress AXI stream in front of the egress boundary. It holds a grant from the first accepted beat to the accepted `tlast` beat, so packets are never interleaved. It drives a registered output stage that carries the source index on `m_tid`.

## Interface
- `NUM_PORTS`, 4: number of requesting streams, ≥1.
- `DATA_WIDTH`, 64: tdata width per stream.
- `USER_WIDTH`, 1: tuser width per stream.
- `ID_WIDTH`, derived as max(1, $clog2(NUM_PORTS)): width of `m_tid`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `s_tdata`  in  NUM_PORTS*DATA_WIDTH  port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `s_tvalid`  in  NUM_PORTS  per-port valid.
- `s_tready`  out  NUM_PORTS  per-port ready.
- `s_tlast`  in  NUM_PORTS  per-port last.
- `s_tuser`  in  NUM_PORTS*USER_WIDTH  per-port user, packed like `s_tdata`.
- `m_tdata`  out  DATA_WIDTH  egress data (registered).
- `m_tvalid`  out  1  egress valid (registered).
- `m_tready`  in  1  egress ready.
- `m_tlast`  out  1  egress last (registered).
- `m_tuser`  out  USER_WIDTH  egress user (registered).
- `m_tid`  out  ID_WIDTH  index of the source port of the current `m_*` beat (registered).

## Operation
- **State:** `state` ∈ {IDLE, BUSY}, `grant` (ID_WIDTH), `rr_ptr` (ID_WIDTH), output register (`m_tdata`, `m_tuser`, `m_tlast`, `m_tid`, `m_tvalid`).
- **Reset:**
  - `state`=IDLE, `grant`=0, `rr_ptr`=0.
  - All `m_*` outputs are 0.
  - `s_tready` is all-zero.
- **IDLE:**
  - `s_tready` is all-zero.
  - If any `s_tvalid` bit is set, latch `grant` = the first set index scanning rr_ptr, rr_ptr+1, … modulo NUM_PORTS, then go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY:**
  - `load` = `s_tvalid[grant]` && (!`m_tvalid` || `m_tready`).
  - `s_tready[grant]` = (!`m_tvalid` || `m_tready`); all other `s_tready` bits are 0.
  - On `load`, the output register takes the granted port's data, user and last, and `m_tid` = `grant`.
  - On `load` with `s_tlast[grant]`=1, go to IDLE and set `rr_ptr` = `grant`+1, wrapping NUM_PORTS-1 → 0.
- **Output register:**
  - `m_tvalid` is set on `load`.
  - `m_tvalid` is cleared on (`m_tvalid` && `m_tready` && !`load`).
  - Otherwise it holds.
  - `m_*` data fields hold while `m_tvalid` && !`m_tready` (AXI stability).
- **Granted port drops `s_tvalid` mid-packet:** stay in BUSY, transfer no beat, never regrant.
- **Other ports:** they may assert `s_tvalid` at any time. They are ignored until the next IDLE arbitration. Their `s_tvalid` need not stay stable before a grant.
- **NUM_PORTS=1:** `rr_ptr` stays 0. Behaviour is otherwise identical.
- **Reset mid-packet:** everything returns to reset values immediately. The in-flight packet is truncated; no recovery or flush. Upstream is responsible for resynchronising.

## Timing
- **Arbitration:** request seen in IDLE in cycle N → `grant` registered at the edge ending N. `s_tready[grant]` is high in cycle N+1 if the output register is free.
- **First-beat latency:** a beat accepted in cycle N+1 appears on `m_*` in cycle N+2. Latency from request to `m_tvalid` is 2 cycles.
- **Throughput within a packet:** 1 beat/cycle when `m_tready` is held high. Ready pass-through is combinational from `m_tready` to `s_tready`.
- **Between packets:** exactly one IDLE cycle follows each accepted `tlast`, giving one bubble on the slave side per packet. The output side may show the bubble as `m_tvalid`=0 for one cycle.
- **Backpressure:** with `m_tready`=0 and `m_tvalid`=1, `s_tready`=0 and no beat is lost or duplicated.
- **Fairness:** a port continuously requesting waits at most NUM_PORTS-1 packets.

## Test plan
- **Reset values:** assert `rst` asynchronously mid-cycle → all `m_*` and `s_tready` become 0 before the next edge. After release, the first arbitration scans from port 0.
- **Single port:** port 2 sends a 3-beat packet with `m_tready`=1 → `m_tvalid` high cycles 2–4, `m_tid`=2, `m_tlast` only on beat 3; `rr_ptr`=3 afterwards.
- **Round-robin:** all 4 ports continuously offer 2-beat packets → grant order 0,1,2,3,0. No interleaving inside any packet; one IDLE cycle between packets.
- **Wrap-around:** `rr_ptr`=3, requests on ports 1 and 3 → port 3 is served first. Next `rr_ptr`=0, so port 1 is served next.
- **Backpressure:** random `m_tready` (50%) on a 16-beat packet from port 0 → all 16 beats emerge in order, each stable while stalled; `s_tready[0]`=0 whenever `m_tvalid`=1 and `m_tready`=0.
- **Valid gap:** the granted port deasserts `s_tvalid` for 3 cycles mid-packet while port 1 requests → the grant is held. Port 1 receives `s_tready`=0 throughout and is granted only after the `tlast` beat.
